// File: rtl/mv_search_sched.sv
// Full-search motion-estimation scheduler: init phase, credit-limited raster
// issue of candidate displacements, in-order SAD collection and minimum tracking.
module mv_search_sched #(
  parameter int unsigned RANGE       = 4,
  parameter int unsigned MV_W        = 5,
  parameter int unsigned SAD_W       = 12,
  parameter int unsigned INIT_CYCLES = 73,
  parameter int unsigned MAX_OUT     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    en_init,
  output logic                    cand_valid,
  input  logic                    cand_ready,
  output logic signed [MV_W-1:0]  cand_dx,
  output logic signed [MV_W-1:0]  cand_dy,
  input  logic                    sad_valid,
  input  logic [SAD_W-1:0]        sad,
  output logic                    mv_valid,
  output logic signed [MV_W-1:0]  mv_dx,
  output logic signed [MV_W-1:0]  mv_dy,
  output logic [SAD_W-1:0]        mv_sad,
  output logic                    err
);

  localparam int unsigned TOTAL  = (2 * RANGE + 1) * (2 * RANGE + 1);
  localparam int unsigned CNT_W  = $clog2(TOTAL + 1);
  localparam int unsigned OUT_W  = $clog2(MAX_OUT + 1);
  localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic signed [MV_W-1:0] POS_R = MV_W'(RANGE);
  localparam logic signed [MV_W-1:0] NEG_R = -POS_R;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [INIT_W-1:0]        init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0]         iss_cnt_q, iss_cnt_d, res_cnt_q, res_cnt_d;
  logic [OUT_W-1:0]         out_q, out_d;
  logic signed [MV_W-1:0]   res_dx_q, res_dx_d, res_dy_q, res_dy_d;
  logic signed [MV_W-1:0]   best_dx_q, best_dx_d, best_dy_q, best_dy_d;
  logic [SAD_W-1:0]         best_sad_q, best_sad_d;
  logic                     busy_q, busy_d, en_init_q, en_init_d;
  logic                     cand_valid_q, cand_valid_d, mv_valid_q, mv_valid_d;
  logic signed [MV_W-1:0]   cand_dx_q, cand_dx_d, cand_dy_q, cand_dy_d;
  logic signed [MV_W-1:0]   mv_dx_q, mv_dx_d, mv_dy_q, mv_dy_d;
  logic [SAD_W-1:0]         mv_sad_q, mv_sad_d;
  logic                     err_q, err_d;
  logic                     xfer_c, acc_c;

  assign xfer_c = cand_valid_q & cand_ready;
  // A result is only meaningful while running with a candidate in flight.
  assign acc_c  = sad_valid && (state_q == S_RUN) && (out_q != '0);

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    iss_cnt_d    = iss_cnt_q;
    res_cnt_d    = res_cnt_q;
    out_d        = out_q;
    res_dx_d     = res_dx_q;
    res_dy_d     = res_dy_q;
    best_dx_d    = best_dx_q;
    best_dy_d    = best_dy_q;
    best_sad_d   = best_sad_q;
    busy_d       = busy_q;
    en_init_d    = en_init_q;
    cand_valid_d = cand_valid_q;
    cand_dx_d    = cand_dx_q;
    cand_dy_d    = cand_dy_q;
    mv_valid_d   = 1'b0;
    mv_dx_d      = mv_dx_q;
    mv_dy_d      = mv_dy_q;
    mv_sad_d     = mv_sad_q;
    err_d        = err_q;

    if (sad_valid && !acc_c) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_INIT;
          busy_d       = 1'b1;
          en_init_d    = 1'b1;
          init_cnt_d   = '0;
          iss_cnt_d    = '0;
          res_cnt_d    = '0;
          out_d        = '0;
          cand_dx_d    = NEG_R;
          cand_dy_d    = NEG_R;
          res_dx_d     = NEG_R;
          res_dy_d     = NEG_R;
          best_dx_d    = NEG_R;
          best_dy_d    = NEG_R;
          best_sad_d   = '1;
          mv_dx_d      = '0;
          mv_dy_d      = '0;
          mv_sad_d     = '0;
          err_d        = sad_valid;
        end
      end
      S_INIT: begin
        init_cnt_d = init_cnt_q + INIT_W'(1);
        if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
          state_d      = S_RUN;
          en_init_d    = 1'b0;
          cand_valid_d = 1'b1;
        end
      end
      S_RUN: begin
        if (xfer_c) begin
          iss_cnt_d = iss_cnt_q + CNT_W'(1);
          if (cand_dx_q == POS_R) begin
            cand_dx_d = NEG_R;
            cand_dy_d = cand_dy_q + MV_W'(1);
          end else begin
            cand_dx_d = cand_dx_q + MV_W'(1);
          end
        end
        if (acc_c) begin
          res_cnt_d = res_cnt_q + CNT_W'(1);
          // Strict compare keeps the earliest raster candidate on ties.
          if (sad < best_sad_q) begin
            best_sad_d = sad;
            best_dx_d  = res_dx_q;
            best_dy_d  = res_dy_q;
          end
          if (res_dx_q == POS_R) begin
            res_dx_d = NEG_R;
            res_dy_d = res_dy_q + MV_W'(1);
          end else begin
            res_dx_d = res_dx_q + MV_W'(1);
          end
        end
        out_d        = out_q + OUT_W'(xfer_c) - OUT_W'(acc_c);
        cand_valid_d = (iss_cnt_d < CNT_W'(TOTAL)) && (out_d < OUT_W'(MAX_OUT));
        if (res_cnt_d == CNT_W'(TOTAL)) begin
          state_d      = S_DONE;
          cand_valid_d = 1'b0;
          mv_valid_d   = 1'b1;
          mv_dx_d      = best_dx_d;
          mv_dy_d      = best_dy_d;
          mv_sad_d     = best_sad_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      init_cnt_q   <= '0;
      iss_cnt_q    <= '0;
      res_cnt_q    <= '0;
      out_q        <= '0;
      res_dx_q     <= '0;
      res_dy_q     <= '0;
      best_dx_q    <= '0;
      best_dy_q    <= '0;
      best_sad_q   <= '1;
      busy_q       <= 1'b0;
      en_init_q    <= 1'b0;
      cand_valid_q <= 1'b0;
      cand_dx_q    <= '0;
      cand_dy_q    <= '0;
      mv_valid_q   <= 1'b0;
      mv_dx_q      <= '0;
      mv_dy_q      <= '0;
      mv_sad_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      iss_cnt_q    <= iss_cnt_d;
      res_cnt_q    <= res_cnt_d;
      out_q        <= out_d;
      res_dx_q     <= res_dx_d;
      res_dy_q     <= res_dy_d;
      best_dx_q    <= best_dx_d;
      best_dy_q    <= best_dy_d;
      best_sad_q   <= best_sad_d;
      busy_q       <= busy_d;
      en_init_q    <= en_init_d;
      cand_valid_q <= cand_valid_d;
      cand_dx_q    <= cand_dx_d;
      cand_dy_q    <= cand_dy_d;
      mv_valid_q   <= mv_valid_d;
      mv_dx_q      <= mv_dx_d;
      mv_dy_q      <= mv_dy_d;
      mv_sad_q     <= mv_sad_d;
      err_q        <= err_d;
    end
  end

  assign busy       = busy_q;
  assign en_init    = en_init_q;
  assign cand_valid = cand_valid_q;
  assign cand_dx    = cand_dx_q;
  assign cand_dy    = cand_dy_q;
  assign mv_valid   = mv_valid_q;
  assign mv_dx      = mv_dx_q;
  assign mv_dy      = mv_dy_q;
  assign mv_sad     = mv_sad_q;
  assign err        = err_q;

endmodule
